// File: rtl/atari_bus_pkg.sv
// Shared types and constants for the CPU/MARIA bus sequencer.
package atari_bus_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    GRANT = 2'd2,
    REL   = 2'd3
  } seq_state_t;

  localparam int DB_W      = 8;
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/cpu_dma_bus_sequencer_if.sv
// CPU/DMA handshake and data signals seen by the bus sequencer.
interface cpu_dma_bus_sequencer_if #(
  parameter int CNT_W = atari_bus_pkg::CNT_W_DEF
);
  logic                          cpu_ce;
  logic                          cpu_rd;
  logic [atari_bus_pkg::DB_W-1:0] db_in;
  logic                          dma_req;
  logic                          dma_done;
  logic                          frame_start;
  logic                          halt_b;
  logic                          dma_grant;
  logic [atari_bus_pkg::DB_W-1:0] cpu_di;
  logic [CNT_W-1:0]              stolen_cnt;
  logic                          wr_run_err;

  modport slave (
    input  cpu_ce, cpu_rd, db_in, dma_req, dma_done, frame_start,
    output halt_b, dma_grant, cpu_di, stolen_cnt, wr_run_err
  );

  modport master (
    output cpu_ce, cpu_rd, db_in, dma_req, dma_done, frame_start,
    input  halt_b, dma_grant, cpu_di, stolen_cnt, wr_run_err
  );
endinterface

// File: rtl/cpu_db_hold.sv
// Holds the CPU read data captured at the stall point so the core sees a
// stable registered value for the whole DMA window.
module cpu_db_hold
  import atari_bus_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            capture_i,
  input  logic            release_i,
  input  logic [DB_W-1:0] db_i,
  output logic [DB_W-1:0] cpu_di_o
);

  logic            hold_q;
  logic [DB_W-1:0] hold_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q      <= 1'b0;
      hold_data_q <= '0;
    end else begin
      if (capture_i) begin
        hold_q      <= 1'b1;
        hold_data_q <= db_i;
      end else if (release_i) begin
        hold_q <= 1'b0;
      end
    end
  end

  assign cpu_di_o = hold_q ? hold_data_q : db_i;

endmodule

// File: rtl/cpu_dma_bus_sequencer.sv
// Arbitrates the system bus between the 6502 core and MARIA DMA: halts the CPU,
// waits for a read stall, grants DMA, hands back, and counts stolen cycles.
module cpu_dma_bus_sequencer
  import atari_bus_pkg::*;
#(
  parameter int MAX_WR_RUN = 3,
  parameter int MIN_GAP    = 0,
  parameter int CNT_W      = CNT_W_DEF
)(
  input  logic                     clk,
  input  logic                     reset_n,
  cpu_dma_bus_sequencer_if.slave   bus
);

  // One extra code point so a run of MAX_WR_RUN+1 writes is representable.
  localparam int WR_W  = $clog2(MAX_WR_RUN + 2);
  localparam int GAP_W = $clog2(MIN_GAP + 2);
  localparam logic [WR_W-1:0]  WR_MAX  = WR_W'(MAX_WR_RUN);
  localparam logic [GAP_W-1:0] GAP_INI = GAP_W'(MIN_GAP);

  seq_state_t       state_q, state_d;
  logic [WR_W-1:0]  wr_run_q, wr_run_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] stolen_q, stolen_d;
  logic             err_q, err_d;
  logic             capture;
  logic             rel_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      wr_run_q <= '0;
      gap_q    <= '0;
      stolen_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_run_q <= wr_run_d;
      gap_q    <= gap_d;
      stolen_q <= stolen_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_run_d = wr_run_q;
    gap_d    = gap_q;
    stolen_d = stolen_q;
    err_d    = err_q;
    capture  = 1'b0;
    rel_hold = 1'b0;

    case (state_q)
      RUN: begin
        wr_run_d = '0;
        if (bus.cpu_ce && (gap_q != '0)) gap_d = gap_q - GAP_W'(1);
        if (bus.dma_req && (gap_q == '0)) state_d = PEND;
      end
      PEND: begin
        // A withdrawn request wins over a read completing on the same clk.
        if (!bus.dma_req) begin
          state_d  = RUN;
          wr_run_d = '0;
        end else if (bus.cpu_ce) begin
          if (bus.cpu_rd) begin
            capture  = 1'b1;
            state_d  = GRANT;
            wr_run_d = '0;
          end else begin
            if (wr_run_q <= WR_MAX) wr_run_d = wr_run_q + WR_W'(1);
            if (wr_run_q >= WR_MAX) err_d = 1'b1;
          end
        end
      end
      GRANT: begin
        if (bus.cpu_ce && (stolen_q != '1)) stolen_d = stolen_q + CNT_W'(1);
        if (bus.dma_done) state_d = REL;
      end
      REL: begin
        if (bus.cpu_ce) begin
          state_d  = RUN;
          rel_hold = 1'b1;
          gap_d    = GAP_INI;
        end
      end
      default: state_d = RUN;
    endcase

    if (bus.frame_start) begin
      stolen_d = '0;
      err_d    = 1'b0;
    end
  end

  cpu_db_hold u_db_hold (
    .clk       (clk),
    .reset_n   (reset_n),
    .capture_i (capture),
    .release_i (rel_hold),
    .db_i      (bus.db_in),
    .cpu_di_o  (bus.cpu_di)
  );

  assign bus.halt_b     = !((state_q == PEND) || (state_q == GRANT));
  assign bus.dma_grant  = (state_q == GRANT);
  assign bus.stolen_cnt = stolen_q;
  assign bus.wr_run_err = err_q;

endmodule
